// File: rtl/riscv_muldiv_pkg.sv
// riscv_pkg: M-extension func3 codes and the muldiv control state encoding.
package riscv_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [2:0] {S_IDLE, S_ITER, S_MULW, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/riscv_muldiv_neg.sv
// riscv_muldiv_neg: conditional two's-complement negator.
module riscv_muldiv_neg #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = en ? (~a) + W'(1) : a;
endmodule

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: shared iterative RV32M/RV64M multiply/divide unit with tagged valid/ready handshake.
// Define RISCV_MULDIV_FAST_MUL_EN to replace multiply iteration by one registered multiplier.
module riscv_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CW = $clog2(XLEN);
  state_t state, state_nx;
  logic [2:0] op;
  logic sgn;
  logic [CW-1:0] cnt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] opnd;
  logic sa, sb, b_zero, ovf, special, accept, fast_mul;
  logic [XLEN-1:0] a_abs, b_abs, spec_res;
  logic [XLEN:0] mul_sum, div_sh, div_df;
  logic [2*XLEN-1:0] mul_nx, div_nx, fix_in, fix_out;
  logic [XLEN-1:0] fix_res;
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign accept    = in_valid & in_ready & ~flush;
`ifdef RISCV_MULDIV_FAST_MUL_EN
  assign fast_mul = ~in_op[2];
`else
  assign fast_mul = 1'b0;
`endif
  always_comb begin
    sa       = in_a[XLEN-1] & (in_op != F3_MULHU) & (in_op != F3_DIVU) & (in_op != F3_REMU);
    sb       = in_b[XLEN-1] & (in_op != F3_MULHU) & (in_op != F3_DIVU) & (in_op != F3_REMU) & (in_op != F3_MULHSU);
    b_zero   = in_b == '0;
    ovf      = (in_op == F3_DIV || in_op == F3_REM) && in_a == {1'b1, {(XLEN-1){1'b0}}} && &in_b;
    special  = in_op[2] & (b_zero | ovf);
    spec_res = b_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : in_a);
  end
  riscv_muldiv_neg #(.W(XLEN)) u_abs_a (.en(sa), .a(in_a), .y(a_abs));
  riscv_muldiv_neg #(.W(XLEN)) u_abs_b (.en(sb), .a(in_b), .y(b_abs));
  // prod holds {upper accumulator, shifting operand} for both multiply and divide
  always_comb begin
    mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    mul_nx  = {mul_sum, prod[XLEN-1:1]};
    div_sh  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    div_df  = div_sh - {1'b0, opnd};
    div_nx  = div_df[XLEN] ? {div_sh[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                           : {div_df[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    fix_in  = ~op[2] ? prod : {{XLEN{1'b0}}, op[1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]};
  end
  riscv_muldiv_neg #(.W(2*XLEN)) u_fix (.en(sgn), .a(fix_in), .y(fix_out));
  assign fix_res = (op == F3_MUL || op[2]) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = special ? S_DONE : fast_mul ? S_MULW : S_ITER;
      S_ITER:  if (cnt == '0) state_nx = S_FIX;
      S_MULW:  state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op         <= '0;
      sgn        <= 1'b0;
      cnt        <= '0;
      prod       <= '0;
      opnd       <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      state <= state_nx;
      if (!flush) begin
        case (state)
          S_IDLE: if (accept) begin
            op      <= in_op;
            out_tag <= in_tag;
            sgn     <= (in_op[2] & in_op[1]) ? sa : sa ^ sb;
            cnt     <= CW'(XLEN - 1);
            opnd    <= in_op[2] ? b_abs : a_abs;
            prod    <= {{XLEN{1'b0}}, in_op[2] ? a_abs : b_abs};
            if (special) out_result <= spec_res;
          end
          S_ITER: begin
            prod <= op[2] ? div_nx : mul_nx;
            cnt  <= cnt - CW'(1);
          end
`ifdef RISCV_MULDIV_FAST_MUL_EN
          S_MULW: prod <= (2*XLEN)'(opnd) * (2*XLEN)'(prod[XLEN-1:0]);
`endif
          S_FIX: out_result <= fix_res;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: directed and random checks of riscv_muldiv against an arithmetic reference model.
module tb_riscv_muldiv;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [2:0] in_op = 0;
  logic [31:0] in_a = 0, in_b = 0, out_result;
  logic [4:0] in_tag = 0, out_tag;
  int checks = 0, errors = 0;
  riscv_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    ub = {32'b0, b};
    up = {32'b0, a} * {32'b0, b};
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = (sa * sb) >>> 32;
      3'd2: p = (sa * ub) >>> 32;
      3'd3: p = up >> 32;
      3'd4: p = (b == 0) ? -64'sd1 : sa / sb;
      3'd5: p = (b == 0) ? -64'sd1 : {32'b0, a / b};
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? {32'b0, a} : {32'b0, a % b};
    endcase
    return p[31:0];
  endfunction
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input int hold);
    int lat;
    logic [31:0] exp_res;
    exp_res = ref_res(op, a, b);
    @(negedge clk);
    chk("ready_before", in_ready, 1);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("lat op%0d a%h b%h", op, a, b), 64'(lat), 64'(ref_lat(op, a, b)));
    chk($sformatf("res op%0d a%h b%h", op, a, b), out_result, exp_res);
    chk("tag", out_tag, tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_res", out_result, exp_res);
      chk("hold_tag", out_tag, tag);
      chk("hold_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("ready_after", in_ready, 1);
    chk("valid_after", out_valid, 0);
  endtask
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1; in_op = 3'd4; in_a = a; in_b = b; in_tag = 5'd3;
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  initial begin
    int seen;
    logic [2:0] op;
    logic [31:0] a, b;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_res", out_result, 0);
    chk("rst_tag", out_tag, 0);
    @(negedge clk);
    rst_n = 1;
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);
    run(3'd5, 32'd100, 32'd0, 5'd3, 0);
    run(3'd7, 32'd100, 32'd0, 5'd4, 0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 0);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 0);
    run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0);
    run(3'd0, 32'h8000_0000, 32'd3, 5'd11, 0);
    run(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'h1F, 10);
    // flush beats a simultaneous request
    @(negedge clk);
    in_valid = 1; in_op = 3'd5; in_a = 32'd9; in_b = 32'd3; flush = 1;
    #1 chk("flush_acc_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("flush_acc_ready2", in_ready, 1);
    chk("flush_acc_valid", out_valid, 0);
    // flush with 15 iterations left
    start_div(32'd1000, 32'd7);
    repeat (16) @(posedge clk);
    @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      seen += int'(out_valid);
    end
    chk("flush_no_valid", 64'(seen), 0);
    // asynchronous reset mid-iteration
    start_div(32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_valid", out_valid, 0);
    chk("arst_res", out_result, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      seen += int'(out_valid);
    end
    chk("arst_no_valid", 64'(seen), 0);
    run(3'd5, 32'd9, 32'd3, 5'd12, 0);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run(op, a, b, 5'($urandom), i % 4 == 0 ? 2 : 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
Parametrised multi-cycle RV32M/RV64M multiply/divide unit. Replaces the separate fixed 32-bit multiplier and divider used by the in-order core with one shared shift-add / shift-subtract datapath. It implements all eight M-extension ops, including the architectural divide-by-zero and overflow results. The core hands it operands over a valid/ready handshake and gets back a tagged result.

Parameters:
XLEN, 32, operand/result width; even, >= 8.
TAG_W, 5, width of opaque tag carried from request to response (core uses rd).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request.
in_op  in  3  M-ext func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
in_a  in  XLEN  rs1 operand (dividend / multiplicand).
in_b  in  XLEN  rs2 operand (divisor / multiplier).
in_tag  in  TAG_W  tag, returned unchanged.
flush  in  1  synchronous abort of any in-flight op.
out_valid  out  1  result valid.
out_ready  in  1  consumer takes result.
out_result  out  XLEN  result.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, counter=0, accumulators=0.
- Accept: in_valid & in_ready at a rising edge. Latch op and tag. Latch |a| and |b| (negated only for signed ops with negative operand; MULHSU negates a only). Latch the result-sign flag: MUL*/DIV sign = sa^sb; REM sign = sa.
- States:
  - IDLE: in_ready=1. On accept go to ITER. If the op is a special case, go straight to DONE.
  - ITER: one bit per cycle for XLEN cycles, counter XLEN-1 down to 0. Multiply uses a 2*XLEN product register and shift-add. Divide uses restoring shift-subtract with remainder and quotient registers. At counter==0 go to FIX.
  - FIX: negate the 2*XLEN product, quotient or remainder if the sign flag is set. Select the result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder. Register it in out_result and go to DONE.
  - DONE: out_valid=1 and out_result/out_tag stable until out_ready. On out_valid & out_ready go to IDLE. No accept in the same cycle (in_ready=0 outside IDLE).
- Latency, accept edge to the first cycle out_valid=1: normal ops XLEN+2 edges; special cases 1 edge.
- Special cases, decided at accept with no iteration:
  - b==0: DIV/DIVU = all ones; REM/REMU = a.
  - Signed overflow (a = 1 followed by XLEN-1 zeros, b = all ones): DIV = a; REM = 0.
- MUL of the most-negative value: abs(a) is treated as unsigned XLEN bits, so the unsigned product is correct and the sign fix gives the correct 2*XLEN result.
- flush (any state): next edge goes to IDLE, out_valid=0, pending result dropped. flush wins over a simultaneous accept: the request is not taken and in_ready is still 1 that cycle, so the core must drop it.
- Async reset mid-operation aborts immediately; no partial result is ever presented.
- Output backpressure: stalling in DONE holds all outputs; the datapath does not advance.

Optional Feature:
RISCV_MULDIV_FAST_MUL_EN:
- Defined: MUL* ops use one registered combinational XLEN x XLEN multiply of the absolute values instead of ITER. Path is IDLE -> MULW (product register loads) -> FIX -> DONE, latency 3 edges. Divide is unchanged.
- Undefined: all ops iterate; no hardware multiplier is inferred.

Decomposition:
- Shared package riscv_pkg: M-ext func3 localparams (F3_MUL..F3_REMU), state encoding (S_IDLE, S_ITER, S_MULW, S_FIX, S_DONE).
- One natural sub-module: riscv_muldiv_neg, a parametrised conditional two's-complement negator (width, enable), used for operand abs and result fixup.

Test Plan:
- XLEN=32, DIV a=-7 (0xFFFFFFF9), b=2 -> out_result 0xFFFFFFFD (-3), out_valid 34 edges after accept; REM same operands -> 0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> 0xFFFFFFFF after 1 edge; REMU a=100, b=0 -> 100.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0; both with 1-edge latency.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE; MUL -> 0x00000001.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid, result and tag (0x1F) stable, in_ready=0. Then out_ready=1 -> in_ready=1 next cycle.
- flush at ITER counter 15, and deassert rst_n mid-ITER -> out_valid never asserts, in_ready=1 after one edge (flush) or immediately (reset). The next DIVU 9/3 returns 3.
